// File: rtl/rr_dispatch4.sv
// rr_dispatch4: registered round-robin 1-to-4 valid/ready dispatcher with per-channel enable mask
//   clk, rst_n        clock, async active-low reset
//   din/in_valid/in_ready   input stream
//   ch_en             per-channel rotation enable
//   dout0..3/out_valid/out_ready   four output channels (dout is 0 when not selected)
//   sel, busy         tag of held word, holding register full
//   cnt0..3           drain counters, present only with RR_DISPATCH_CNT_EN defined
module rr_dispatch4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ch_en,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       sel,
  output logic             busy
`ifdef RR_DISPATCH_CNT_EN
  ,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2,
  output logic [7:0]       cnt3
`endif
);
  logic [WIDTH-1:0] hold;
  logic [1:0] tag, ptr, nxt, off;
  logic [7:0] dbl;
  logic full, acc, drn;
  assign in_ready = rst_n && ch_en[ptr] && (!full || out_ready[tag]);
  assign acc = in_valid && in_ready;
  assign drn = full && out_ready[tag];
  // dbl[k] is ch_en[ptr+1+k]; first set bit gives the cyclic step, falling back to ptr itself
  assign dbl = {ch_en, ch_en} >> (3'(ptr) + 3'd1);
  assign off = dbl[0] ? 2'd1 : dbl[1] ? 2'd2 : dbl[2] ? 2'd3 : 2'd0;
  assign nxt = ptr + off;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      tag  <= '0;
      ptr  <= '0;
      full <= 1'b0;
    end else begin
      if (acc) begin
        hold <= din;
        tag  <= ptr;
      end
      full <= acc || (full && !drn);
      if (acc || !ch_en[ptr]) ptr <= nxt;
    end
  end
  assign out_valid = {3'b000, full} << tag;
  assign dout0 = (full && tag == 2'd0) ? hold : '0;
  assign dout1 = (full && tag == 2'd1) ? hold : '0;
  assign dout2 = (full && tag == 2'd2) ? hold : '0;
  assign dout3 = (full && tag == 2'd3) ? hold : '0;
  assign sel = tag;
  assign busy = full;
`ifdef RR_DISPATCH_CNT_EN
  logic [7:0] cnt [4];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (drn) begin
      cnt[tag] <= cnt[tag] + 8'd1;
    end
  end
  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];
  assign cnt3 = cnt[3];
`endif
endmodule

// File: tb/tb_rr_dispatch4.sv
// tb_rr_dispatch4: directed self-checking bench for rr_dispatch4
module tb_rr_dispatch4;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] din;
  logic in_valid, in_ready, busy;
  logic [3:0] ch_en, out_valid, out_ready;
  logic [7:0] dout0, dout1, dout2, dout3;
  logic [1:0] sel;
  int checks = 0;
  int failures = 0;
`ifdef RR_DISPATCH_CNT_EN
  logic [7:0] cnt0, cnt1, cnt2, cnt3;
`endif
  rr_dispatch4 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .ch_en(ch_en), .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .out_valid(out_valid), .out_ready(out_ready), .sel(sel), .busy(busy)
`ifdef RR_DISPATCH_CNT_EN
    , .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask
  task automatic chk_out(input string t, input int ch, input logic [7:0] d);
    chk({t, "_valid"}, {28'd0, out_valid}, 32'(1) << ch);
    chk({t, "_dout"}, {dout3, dout2, dout1, dout0}, 32'(d) << (8 * ch));
    chk({t, "_sel"}, {30'd0, sel}, 32'(ch));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int exp_ch[4];
    rst_n = 1'b0;
    din = '0;
    in_valid = 1'b0;
    ch_en = 4'b1111;
    out_ready = 4'b1111;
    #2;
    chk("rst_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_dout", {dout3, dout2, dout1, dout0}, 32'd0);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    // rotation: five words to channels 0,1,2,3,0
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 8'hA0 + 8'(i);
      #1;
      chk("rot_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk_out("rot", i % 4, 8'hA0 + 8'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("rot_drained", {31'd0, busy}, 32'd0);
    // backpressure: 0x55 held on channel 1
    out_ready = 4'b1101;
    in_valid = 1'b1;
    din = 8'h55;
    tick();
    din = 8'h66;
    for (int i = 0; i < 3; i++) begin
      chk_out("bp_hold", 1, 8'h55);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 4'b1111;
    #1;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_out("bp_next", 2, 8'h66);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", {31'd0, busy}, 32'd0);
    // bring ptr to 0, then mask re-points it to 1
    in_valid = 1'b1;
    din = 8'hC0;
    tick();
    chk_out("pre_mask", 3, 8'hC0);
    in_valid = 1'b0;
    ch_en = 4'b1010;
    tick();
    exp_ch = '{1, 3, 1, 3};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 8'hB0 + 8'(i);
      #1;
      chk("mask_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk_out("mask", exp_ch[i], 8'hB0 + 8'(i));
    end
    in_valid = 1'b0;
    tick();
    ch_en = 4'b0000;
    in_valid = 1'b1;
    #1;
    chk("mask_zero_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("mask_zero_busy", {31'd0, busy}, 32'd0);
    // held word on channel 2 survives its enable being cleared
    ch_en = 4'b1111;
    din = 8'hD1;
    tick();
    chk_out("held_d1", 1, 8'hD1);
    out_ready = 4'b1011;
    din = 8'hD2;
    tick();
    in_valid = 1'b0;
    chk_out("held_d2", 2, 8'hD2);
    ch_en = 4'b1011;
    tick();
    chk_out("held_masked", 2, 8'hD2);
    out_ready = 4'b1111;
    in_valid = 1'b1;
    din = 8'hD3;
    tick();
    chk_out("held_next", 3, 8'hD3);
    in_valid = 1'b0;
    tick();
    // reset with a word held and ptr=2
    ch_en = 4'b1111;
    in_valid = 1'b1;
    din = 8'hE0;
    tick();
    din = 8'hE1;
    tick();
    in_valid = 1'b0;
    out_ready = 4'b0000;
    tick();
    chk_out("pre_rst", 1, 8'hE1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {28'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_sel", {30'd0, sel}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 4'b1111;
    in_valid = 1'b1;
    din = 8'hE5;
    tick();
    chk_out("post_rst", 0, 8'hE5);
    in_valid = 1'b0;
    tick();
`ifdef RR_DISPATCH_CNT_EN
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    ch_en = 4'b0001;
    in_valid = 1'b1;
    din = 8'h11;
    for (int i = 0; i < 257; i++) tick();
    in_valid = 1'b0;
    tick();
    chk("cnt0", {24'd0, cnt0}, 32'd1);
    chk("cnt1", {24'd0, cnt1}, 32'd0);
    chk("cnt2", {24'd0, cnt2}, 32'd0);
    chk("cnt3", {24'd0, cnt3}, 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_dispatch4.md
# rr_dispatch4

Registered round-robin 1-to-4 dispatcher that sits directly upstream of the four-way output fan-out. It accepts a single valid/ready input stream and hands each word, in turn, to one of four valid/ready output channels. It presents the channel select as a 2-bit `sel` so downstream demux logic and debug see the same routing decision. A per-channel enable mask lets software take channels out of rotation without stalling the stream.

## Interface
- `WIDTH`, 8, data width of `din` and each `doutN`
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `din`  in  WIDTH  input word
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  dispatcher can accept `din` this cycle
- `ch_en`  in  4  per-channel enable; bit N allows channel N in rotation
- `dout0`..`dout3`  out  WIDTH each  channel data; 0 when that channel is not selected
- `out_valid`  out  4  one-hot (or zero) valid, bit N for channel N
- `out_ready`  in  4  per-channel ready
- `sel`  out  2  channel of the word currently held (the `tag`)
- `busy`  out  1  holding register full

## Operation
- One-entry holding register `buf`, with tag `tag[1:0]` and flag `full`. Round-robin pointer `ptr[1:0]`.
- Accept when `in_valid && in_ready`.
- `in_ready = ch_en[ptr] && (!full || out_ready[tag])`, so pass-through gives 1 word/cycle.
- On accept:
  - `buf<=din`, `tag<=ptr`, `full<=1`.
  - `ptr` advances to the first enabled channel in cyclic order ptr+1, ptr+2, ptr+3, ptr (3 wraps to 0).
  - If only `ptr` is enabled, `ptr` stays.
- Drain when `full && out_ready[tag]`.
  - Drain without accept: `full<=0`.
  - Drain with accept in the same cycle: the register reloads and `full` stays 1.
- Idle re-point: when no accept occurs and `ch_en[ptr]==0`, `ptr` moves to the next enabled channel by the same search. If `ch_en==0`, `ptr` holds and `in_ready=0`.
- Outputs:
  - `out_valid[tag]=full`, other bits 0.
  - `dout[tag]=buf`, other `doutN=0`.
  - `sel=tag`, `busy=full`.
- A held word is never dropped or redirected. Clearing `ch_en[tag]` while `full` does not cancel it; it waits for `out_ready[tag]`.
- `ch_en` affects only `ptr` and `in_ready`.

## Timing
- Reset (async assert, sync release):
  - `full=0`, `ptr=0`, `tag=0`, `buf=0`.
  - All outputs 0: `out_valid=0`, `doutN=0`, `sel=0`, `busy=0`.
  - `in_ready=0` while `rst_n=0`.
- Latency: a word accepted at edge N is visible on `out_valid`/`doutN` after edge N; there is no combinational path from `din` to `doutN`.
- `in_ready` depends combinationally on `out_ready` and `ch_en`. `out_valid` and `doutN` depend on registers only.
- Reset mid-transfer discards `buf` and restarts rotation at channel 0.

## Configuration
- `RR_DISPATCH_CNT_EN` defined:
  - Adds outputs `cnt0`..`cnt3` (8 bits each).
  - Each counts completed drains on its channel and wraps 255→0.
  - All counters reset to 0.
- Undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- Rotation:
  - Stimulus: `ch_en=4'b1111`, `out_ready=4'b1111`, `in_valid` held, `din`=A0,A1,A2,A3,A4 on consecutive cycles.
  - Response: channels 0,1,2,3,0 one cycle later; `sel`=0,1,2,3,0; `in_ready` stays 1.
- Backpressure:
  - Stimulus: `out_ready[1]=0` for 3 cycles with word 0x55 tagged 1.
  - Response: `out_valid=4'b0010`, `dout1=0x55` stable, `in_ready=0`; drain on the cycle `out_ready[1]` rises.
- Mask skip:
  - Stimulus: `ch_en=4'b1010`, 4 words.
  - Response: routed to channels 1,3,1,3.
  - Stimulus: `ch_en=0`.
  - Response: `in_ready=0`.
- Held word vs mask:
  - Stimulus: word held on channel 2, then `ch_en[2]` cleared.
  - Response: word still delivered on `dout2` when `out_ready[2]=1`; the next word goes to the next enabled channel.
- Reset mid-operation:
  - Stimulus: assert `rst_n=0` while `busy=1` and `ptr=2`.
  - Response: immediately `out_valid=0`, `busy=0`, `sel=0`. After release, the first word goes to channel 0.
- With `RR_DISPATCH_CNT_EN`:
  - Stimulus: 257 drains on channel 0.
  - Response: `cnt0=1`; other counters 0.
